// File: rtl/traffic_sense.sv
// Vehicle-presence sensing for a two-approach junction: synchronises and debounces
// the raw sensors, keeps a saturating waiting-vehicle count per approach and raises service requests.
module traffic_sense #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 4,
    parameter int THRESH   = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             A_Traffic,
    input  logic             B_Traffic,
    input  logic             A_Light,
    input  logic             B_Light,
    input  logic             A_Pass,
    input  logic             B_Pass,
    output logic [CNT_W-1:0] A_Count,
    output logic [CNT_W-1:0] B_Count,
    output logic             Exsi_Traffic,
    output logic             A_Req,
    output logic             B_Req
);

    // Debounce counter is sized for the largest legal DEBOUNCE (255).
    localparam int               DB_W     = 8;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    // Index 0 is approach A, index 1 is approach B throughout.
    logic [1:0]       raw;
    logic [1:0]       light;
    logic [1:0]       pass;

    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       deb_lvl;
    logic [DB_W-1:0]  db_cnt [2];

    logic [1:0]       db_diff;
    logic [1:0]       db_hit;
    logic [1:0]       arrive;
    logic [1:0]       depart;
    logic [CNT_W-1:0] count     [2];
    logic [CNT_W-1:0] count_nxt [2];
    logic [1:0]       req;
    logic [1:0]       req_nxt;
    logic             exsi_nxt;

    assign raw   = {B_Traffic, A_Traffic};
    assign light = {B_Light, A_Light};
    assign pass  = {B_Pass, A_Pass};

    // Saturating up/down step; a simultaneous arrival and departure cancel out.
    function automatic logic [CNT_W-1:0] sat_step(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            if (cnt != CNT_MAX) begin
                res = cnt + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt != '0) begin
                res = cnt - 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        db_diff  = '0;
        db_hit   = '0;
        arrive   = '0;
        depart   = '0;
        req_nxt  = '0;
        for (int i = 0; i < 2; i++) begin
            count_nxt[i] = count[i];
        end
        for (int i = 0; i < 2; i++) begin
            db_diff[i]   = sync_p1[i] != deb_lvl[i];
            db_hit[i]    = db_diff[i] && (db_cnt[i] == DB_LAST);
            // Only a rising debounced level is an arrival; falling just re-arms the sensor.
            arrive[i]    = db_hit[i] && sync_p1[i];
            depart[i]    = pass[i] && light[i];
            count_nxt[i] = sat_step(count[i], arrive[i], depart[i]);
            req_nxt[i]   = (count_nxt[i] >= THRESH_C) && !light[i];
        end
        exsi_nxt = (count_nxt[0] != '0) || (count_nxt[1] != '0);
    end

    // Stage boundary: two-flop synchroniser, then debounce and counters.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_p0      <= '0;
            sync_p1      <= '0;
            deb_lvl      <= '0;
            req          <= '0;
            Exsi_Traffic <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            sync_p0      <= raw;
            sync_p1      <= sync_p0;
            req          <= req_nxt;
            Exsi_Traffic <= exsi_nxt;
            for (int i = 0; i < 2; i++) begin
                if (!db_diff[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_hit[i]) begin
                    deb_lvl[i] <= sync_p1[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
                count[i] <= count_nxt[i];
            end
        end
    end

    assign A_Count = count[0];
    assign B_Count = count[1];
    assign A_Req   = req[0];
    assign B_Req   = req[1];

endmodule

// File: doc/traffic_sense.md
TRAFFIC_SENSE -- requirements
Module: traffic_sense

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable cycles (after synchroniser) needed to accept a sensor level change; legal range 2..255.
REQ-002 Parameter CNT_W, default 4: width of each per-approach waiting-vehicle counter.
REQ-003 Parameter THRESH, default 3: queue depth at which a service request is raised; legal range 1..2^CNT_W-1.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 A_Traffic  input  1  raw, asynchronous vehicle-presence sensor, approach A; bouncy.
REQ-007 B_Traffic  input  1  raw, asynchronous vehicle-presence sensor, approach B; bouncy.
REQ-008 A_Light  input  1  current light for A from the light controller; 1 = green.
REQ-009 B_Light  input  1  current light for B; 1 = green.
REQ-010 A_Pass  input  1  one-cycle pulse: one vehicle left approach A; synchronous to Clk.
REQ-011 B_Pass  input  1  one-cycle pulse: one vehicle left approach B; synchronous to Clk.
REQ-012 A_Count  output  CNT_W  registered vehicles waiting on A.
REQ-013 B_Count  output  CNT_W  registered vehicles waiting on B.
REQ-014 Exsi_Traffic  output  1  registered; 1 when either counter is non-zero.
REQ-015 A_Req  output  1  registered; A queue at or above THRESH while A is red.
REQ-016 B_Req  output  1  registered; B queue at or above THRESH while B is red.

Function
REQ-017 Each raw sensor shall pass through a two-flop synchroniser before any other logic.
REQ-018 Per approach, a debounce counter shall count cycles where synchronised level differs from debounced level; it clears on any cycle they match.
REQ-019 When the counter would reach DEBOUNCE, the debounced level shall take the synchronised level and the counter clears on that same edge.
REQ-020 Latency: a clean raw edge changes the debounced level exactly DEBOUNCE+2 cycles later; glitches shorter than DEBOUNCE synchronised cycles are ignored.
REQ-021 An arrival is a debounced 0->1 transition; it increments that approach's count on the same edge the debounced level rises.
REQ-022 A departure is an X_Pass pulse while X_Light=1; it decrements that count. X_Pass while X_Light=0 is ignored.
REQ-023 Arrival and departure on the same edge for one approach shall leave the count unchanged.
REQ-024 The count shall saturate at 2^CNT_W-1: an arrival at max is dropped.
REQ-025 The count shall floor at 0: a departure at 0 is dropped.
REQ-026 Exsi_Traffic, A_Req and B_Req shall be computed from the next-state counts and lights, and registered, so they change on the same edge as the counts.
REQ-027 X_Req = (next X_Count >= THRESH) AND (X_Light = 0); it drops on the edge after X_Light goes green.
REQ-028 Approaches A and B are fully independent; simultaneous events on both are all applied.

Reset
REQ-029 With Rst=1 at a rising edge: counts = 0, Exsi_Traffic = 0, A_Req = B_Req = 0, synchronisers = 0, debounced levels = 0, debounce counters = 0.
REQ-030 Reset mid-debounce or mid-queue discards all progress; a sensor still held high after reset is counted as one arrival DEBOUNCE+2 cycles after Rst falls.
REQ-031 Rst has priority over all other inputs on the same edge.

Verification (DEBOUNCE=4, CNT_W=4, THRESH=3)
REQ-032 Rst high 2 cycles, then A_Traffic rises at cycle 0 and holds -> A_Count=1 and Exsi_Traffic=1 from cycle 6; B_Count=0.
REQ-033 A_Traffic pulses high 3 cycles, then 0 -> A_Count remains 0; Exsi_Traffic remains 0.
REQ-034 Three clean A arrivals with A_Light=0 -> A_Req=1 on the edge A_Count becomes 3; set A_Light=1 -> A_Req=0 one edge later.
REQ-035 A_Count=15, one more arrival -> A_Count stays 15; A_Light=1 and 16 A_Pass pulses -> A_Count reaches 0, Exsi_Traffic=0 with B_Count=0, 16th pulse ignored.
REQ-036 A_Count=2, A_Light=1: A_Pass coincides with debounced arrival edge -> A_Count stays 2; A_Pass while A_Light=0 -> A_Count stays 2.
REQ-037 B_Count=5, B_Req=1, assert Rst for one cycle -> all outputs 0 next edge; B_Traffic still high -> B_Count=1 six cycles after Rst falls.
